// File: rtl/inst_fetch_pkg.sv
// Shared constants, FIFO entry payload and pointer-width helper for the fetch front end.
// Optional misaligned-target exception path: INST_FETCH_ADEL_EN.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        Branch       = 1'b1;
  localparam logic        True_v       = 1'b1;
  localparam logic        False_v      = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
`ifdef INST_FETCH_ADEL_EN
    logic        adel;
`endif
  } fetch_entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// SRAM request/response and decoder hand-off signals of the fetch unit.
// inst_adel_o exists only when INST_FETCH_ADEL_EN is defined.
interface inst_fetch_if;

  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_gnt_i;
  logic        inst_sram_rvalid_i;
  logic [31:0] inst_sram_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
`ifdef INST_FETCH_ADEL_EN
  logic        inst_adel_o;
`endif

  modport master (
`ifdef INST_FETCH_ADEL_EN
    output inst_adel_o,
`endif
    output inst_sram_req_o, inst_sram_addr_o, inst_o, inst_addr_o, inst_valid_o,
    input  inst_sram_gnt_i, inst_sram_rvalid_i, inst_sram_rdata_i,
    input  inst_ready_i, branch_flag_i, branch_target_address_i
  );

  modport slave (
`ifdef INST_FETCH_ADEL_EN
    input  inst_adel_o,
`endif
    input  inst_sram_req_o, inst_sram_addr_o, inst_o, inst_addr_o, inst_valid_o,
    output inst_sram_gnt_i, inst_sram_rvalid_i, inst_sram_rdata_i,
    output inst_ready_i, branch_flag_i, branch_target_address_i
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {addr, inst} entries with a flush that
// wins over any same-cycle push or pop.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = ptr_width(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Push is accepted when full only if the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = entry_i;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Head reads as zero when empty so the decoder never sees a stale word.
  always_comb begin
    head_o = '0;
    if (cnt_q != '0) begin
      head_o = mem_q[rd_q];
    end
    if (cnt_q == '0) begin
      head_o.inst = ZeroWord;
    end
  end

  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC, req/gnt/rvalid SRAM protocol, output FIFO and redirect.
// Define INST_FETCH_ADEL_EN to report misaligned redirect targets instead of masking them.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          resetn,
  inst_fetch_if.master bus
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  logic          run_q, run_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   aq_q [DEPTH];
  logic [31:0]   aq_d [DEPTH];
  logic [PW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
`ifdef INST_FETCH_ADEL_EN
  logic          halt_q, halt_d;
  logic          adel_pend_q, adel_pend_d;
`endif

  logic          req_c, grant_c, rvalid_c, pop_c, flush_c, fifo_push_c;
  logic [31:0]   target_c;
  logic [OW-1:0] occupancy_c;
  fetch_entry_t  push_entry_c, head_c;
  logic [CW-1:0] fifo_count_c;
  logic          fifo_full_c, fifo_empty_c;

  inst_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i (flush_c),
    .push_i  (fifo_push_c),
    .entry_i (push_entry_c),
    .pop_i   (pop_c),
    .head_o  (head_c),
    .count_o (fifo_count_c),
    .full_o  (fifo_full_c),
    .empty_o (fifo_empty_c)
  );

  // Request gating, counters, grant-time address queue and redirect.
  always_comb begin
    run_d        = True_v;
    fetch_pc_d   = fetch_pc_q;
    aq_d         = aq_q;
    aq_wr_d      = aq_wr_q;
    aq_rd_d      = aq_rd_q;
    discard_d    = discard_q;
    fifo_push_c  = 1'b0;
    push_entry_c = '0;
`ifdef INST_FETCH_ADEL_EN
    halt_d       = halt_q;
    adel_pend_d  = adel_pend_q;
    target_c     = bus.branch_target_address_i;
`else
    target_c     = bus.branch_target_address_i & ~32'h3;
`endif
    // Every granted-but-unreturned request holds a FIFO slot in reserve.
    occupancy_c  = OW'(outstanding_q) + OW'(fifo_count_c);
    req_c        = run_q & ~fifo_full_c & (occupancy_c < OW'(DEPTH));
`ifdef INST_FETCH_ADEL_EN
    req_c        = req_c & ~halt_q;
`endif
    grant_c      = req_c & bus.inst_sram_gnt_i;
    rvalid_c     = bus.inst_sram_rvalid_i;
    pop_c        = ~fifo_empty_c & bus.inst_ready_i;
    flush_c      = pop_c & (bus.branch_flag_i == Branch);

    outstanding_d = outstanding_q + CW'(grant_c) - CW'(rvalid_c);

    if (grant_c) begin
      aq_d[aq_wr_q] = fetch_pc_q;
      aq_wr_d       = aq_wr_q + PW'(1);
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end

    if (rvalid_c) begin
      aq_rd_d = aq_rd_q + PW'(1);
      if (discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end else begin
        fifo_push_c       = 1'b1;
        push_entry_c.addr = aq_q[aq_rd_q];
        push_entry_c.inst = bus.inst_sram_rdata_i;
      end
    end

    // Everything still in flight after this edge belongs to the wrong path.
    if (flush_c) begin
      fetch_pc_d = target_c;
      discard_d  = outstanding_d;
    end

`ifdef INST_FETCH_ADEL_EN
    if (flush_c) begin
      halt_d      = (target_c[1:0] != 2'b00);
      adel_pend_d = halt_d;
    end else if (adel_pend_q && (outstanding_q == '0) && !fifo_full_c) begin
      fifo_push_c       = 1'b1;
      push_entry_c      = '0;
      push_entry_c.addr = fetch_pc_q;
      push_entry_c.adel = 1'b1;
      adel_pend_d       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q         <= False_v;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      aq_q          <= '{default: '0};
      aq_wr_q       <= '0;
      aq_rd_q       <= '0;
`ifdef INST_FETCH_ADEL_EN
      halt_q        <= 1'b0;
      adel_pend_q   <= 1'b0;
`endif
    end else begin
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      aq_q          <= aq_d;
      aq_wr_q       <= aq_wr_d;
      aq_rd_q       <= aq_rd_d;
`ifdef INST_FETCH_ADEL_EN
      halt_q        <= halt_d;
      adel_pend_q   <= adel_pend_d;
`endif
    end
  end

  assign bus.inst_sram_req_o  = req_c;
  assign bus.inst_sram_addr_o = fetch_pc_q;
  assign bus.inst_o           = head_c.inst;
  assign bus.inst_addr_o      = head_c.addr;
  assign bus.inst_valid_o     = ~fifo_empty_c;
`ifdef INST_FETCH_ADEL_EN
  assign bus.inst_adel_o      = head_c.adel;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: SRAM model, reference PC model and delivery scoreboard.
// Covers DEPTH=2 and DEPTH=4 instances; misaligned-redirect phase when INST_FETCH_ADEL_EN is set.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if bus ();
  inst_fetch_if bus4 ();

  inst_fetch #(.RESET_PC(RPC), .DEPTH(2)) dut  (.clk(clk), .resetn(resetn), .bus(bus));
  inst_fetch #(.RESET_PC(RPC), .DEPTH(4)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4));

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] at;
    logic [31:0] tgt;
  } br_t;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc = 0;
  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  br_t         dir_q[$];
  logic [31:0] model_pc;
  int          model_out, depth_cur;
  bit          use4;
  int unsigned gnt_prob, rv_prob, rdy_prob, br_prob, lat_min, lat_max;
  bit          br_on_gr;
  int          n_grants, n_deliv, n_fgr, first_gnt_cyc, first_valid_cyc;
  bit          prev_stall, chk_redirect;
  logic [31:0] prev_addr, prev_inst, redirect_tgt;
  logic        last_req, last_vld;
  logic [31:0] last_iaddr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic br, input logic [31:0] tgt);
    bus.inst_sram_gnt_i          = g & ~use4;
    bus.inst_sram_rvalid_i       = rv & ~use4;
    bus.inst_sram_rdata_i        = rd;
    bus.inst_ready_i             = rdy & ~use4;
    bus.branch_flag_i            = br;
    bus.branch_target_address_i  = tgt;
    bus4.inst_sram_gnt_i         = g & use4;
    bus4.inst_sram_rvalid_i      = rv & use4;
    bus4.inst_sram_rdata_i       = rd;
    bus4.inst_ready_i            = rdy & use4;
    bus4.branch_flag_i           = br;
    bus4.branch_target_address_i = tgt;
  endtask

  task automatic sample(output logic req, output logic [31:0] raddr, output logic vld,
                        output logic [31:0] iaddr, output logic [31:0] idata, output logic adel);
    req   = use4 ? bus4.inst_sram_req_o  : bus.inst_sram_req_o;
    raddr = use4 ? bus4.inst_sram_addr_o : bus.inst_sram_addr_o;
    vld   = use4 ? bus4.inst_valid_o     : bus.inst_valid_o;
    iaddr = use4 ? bus4.inst_addr_o      : bus.inst_addr_o;
    idata = use4 ? bus4.inst_o           : bus.inst_o;
    adel  = 1'b0;
`ifdef INST_FETCH_ADEL_EN
    adel  = use4 ? bus4.inst_adel_o : bus.inst_adel_o;
`endif
  endtask

  task automatic do_reset(input bit sel4);
    logic req, vld, adel;
    logic [31:0] raddr, iaddr, idata;
    @(negedge clk);
    resetn = 1'b0;
    use4   = sel4;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    sample(req, raddr, vld, iaddr, idata, adel);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_sram_addr", raddr, RPC);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_inst", idata, 32'd0);
    chk("rst_inst_addr", iaddr, 32'd0);
    pend_q.delete();
    exp_q.delete();
    dir_q.delete();
    exp_q.push_back(RPC);
    model_pc        = RPC;
    model_out       = 0;
    depth_cur       = sel4 ? 4 : 2;
    prev_stall      = 1'b0;
    chk_redirect    = 1'b0;
    br_on_gr        = 1'b0;
    n_grants        = 0;
    n_deliv         = 0;
    n_fgr           = 0;
    first_gnt_cyc   = -1;
    first_valid_cyc = -1;
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // One clock: sample at negedge, check, choose inputs for the next posedge, update models.
  task automatic step();
    logic req, vld, gnt, rv, rdy, br, grant, pop, flush, adel;
    logic [31:0] raddr, iaddr, idata, tgt, rdata, e;
    int lat;
    @(negedge clk);
    cyc++;
    sample(req, raddr, vld, iaddr, idata, adel);
    if (req) chk("req_addr", raddr, model_pc);
    if (req) chk("req_aligned", 32'(raddr[1:0]), 32'd0);
    if (chk_redirect) begin
      chk("redirect_addr", raddr, redirect_tgt);
      chk_redirect = 1'b0;
    end
    if (prev_stall) begin
      chk("hold_valid", 32'(vld), 32'd1);
      chk("hold_addr", iaddr, prev_addr);
      chk("hold_inst", idata, prev_inst);
    end
    gnt   = ($urandom_range(99) < gnt_prob);
    rv    = (pend_q.size() > 0) && (pend_q[0].due <= cyc) && ($urandom_range(99) < rv_prob);
    rdata = rv ? inst_of(pend_q[0].addr) : $urandom();
    rdy   = ($urandom_range(99) < rdy_prob);
    pop   = vld & rdy;
    tgt   = $urandom() & 32'hFFFF_FFFC;
    br    = 1'b0;
    if (pop && dir_q.size() > 0 && iaddr == dir_q[0].at) begin
      br  = 1'b1;
      tgt = dir_q[0].tgt;
      void'(dir_q.pop_front());
    end else if (pop && br_on_gr && req && gnt && rv) begin
      br       = 1'b1;
      tgt      = 32'hFFFF_FFF8;
      br_on_gr = 1'b0;
    end else if (pop) begin
      br = ($urandom_range(99) < br_prob);
    end else begin
      br = 1'($urandom_range(1));
    end
    grant = req & gnt;
    flush = pop & br;
    drive(gnt, rv, rdata, rdy, br, tgt);

    if (vld && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop) begin
      n_deliv++;
      e = exp_q.pop_front();
      chk("inst_addr", iaddr, e);
      chk("inst_data", idata, (e[1:0] != 2'b00) ? 32'h0 : inst_of(e));
      chk("inst_adel", 32'(adel), 32'(e[1:0] != 2'b00));
      exp_q.push_back(flush ? tgt : e + 32'd4);
    end
    if (flush && grant && rv) n_fgr++;
    if (rv) void'(pend_q.pop_front());
    if (grant) begin
      lat = int'($urandom_range(lat_max, lat_min));
      pend_q.push_back('{raddr, cyc + lat});
      n_grants++;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    end
    model_out = model_out + int'(grant) - int'(rv);
    if (grant) chk("outstanding_le_depth", 32'(model_out <= depth_cur), 32'd1);
    if (flush) begin
      model_pc     = tgt;
      chk_redirect = 1'b1;
      redirect_tgt = tgt;
    end else if (grant) begin
      model_pc = model_pc + 32'd4;
    end
    prev_stall = vld & ~rdy;
    prev_addr  = iaddr;
    prev_inst  = idata;
    last_req   = req;
    last_vld   = vld;
    last_iaddr = iaddr;
  endtask

  task automatic set_mode(input int unsigned g, input int unsigned rv, input int unsigned rdy,
                          input int unsigned br, input int unsigned lmin, input int unsigned lmax);
    gnt_prob = g;
    rv_prob  = rv;
    rdy_prob = rdy;
    br_prob  = br;
    lat_min  = lmin;
    lat_max  = lmax;
  endtask

  initial begin
    // Streaming with a 1-cycle SRAM.
    do_reset(1'b0);
    set_mode(100, 100, 100, 0, 1, 1);
    repeat (20) step();
    chk("first_valid_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);
    chk("p1_delivered", 32'(n_deliv >= 8), 32'd1);

    // Decoder stall: reservation limits grants, head held; mid-run reset.
    do_reset(1'b0);
    set_mode(100, 100, 0, 0, 1, 1);
    repeat (11) step();
    chk("stall_grants", 32'(n_grants), 32'd2);
    chk("stall_req_low", 32'(last_req), 32'd0);
    chk("stall_valid", 32'(last_vld), 32'd1);
    chk("stall_head_addr", last_iaddr, RPC);
    set_mode(100, 100, 100, 0, 1, 1);
    repeat (15) step();
    chk("p2_delivered", 32'(n_deliv >= 6), 32'd1);

    // Branch with stale requests in flight (3-cycle SRAM).
    do_reset(1'b0);
    set_mode(100, 100, 100, 0, 3, 3);
    dir_q.push_back('{32'hBFC0_0004, 32'hBFC0_0100});
    repeat (30) step();
    chk("p3_branch_taken", 32'(dir_q.size()), 32'd0);
    chk("p3_delivered", 32'(n_deliv >= 5), 32'd1);

    // Flush coinciding with gnt and rvalid, target wrapping past 2^32.
    do_reset(1'b1);
    set_mode(100, 100, 100, 0, 1, 1);
    br_on_gr = 1'b1;
    repeat (30) step();
    chk("p4_flush_gnt_rvalid", 32'(n_fgr), 32'd1);
    chk("p4_delivered", 32'(n_deliv >= 10), 32'd1);

    // Random stalls and branches.
    do_reset(1'b0);
    set_mode(60, 70, 70, 10, 1, 4);
    repeat (10000) step();
    chk("p5_delivered", 32'(n_deliv >= 300), 32'd1);
    do_reset(1'b1);
    set_mode(70, 60, 60, 8, 1, 5);
    repeat (4000) step();
    chk("p5b_delivered", 32'(n_deliv >= 150), 32'd1);

`ifdef INST_FETCH_ADEL_EN
    // Misaligned redirect reports once and halts until the next redirect.
    do_reset(1'b0);
    set_mode(100, 100, 100, 0, 1, 1);
    dir_q.push_back('{32'hBFC0_0004, 32'hBFC0_0102});
    dir_q.push_back('{32'hBFC0_0102, 32'hBFC0_0200});
    repeat (40) step();
    chk("p6_branches_taken", 32'(dir_q.size()), 32'd0);
    chk("p6_delivered", 32'(n_deliv >= 8), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
